mux_arb_nto1: RTL

//  Parametrised N-to-1 datapath mux with registered output and valid/ready handshake on every

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_arb_nto1_if.sv | 28 ++
 rtl/mux_arb_nto1_rr_arbiter.sv | 33 +++
 rtl/mux_arb_nto1.sv | 75 +++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types, defaults and helpers for the N-to-1 arbitrated mux
package mux_pkg;

  localparam int DATA_W = 18;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_if.sv
// rtl/mux_arb_nto1_if.sv - input channels, control and output handshake bundle
interface mux_arb_nto1_if #(
  parameter int WIDTH = 18,
  parameter int N     = 16
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode_rr;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, mode_rr, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode_rr, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// rtl/mux_arb_nto1_rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;
  logic           found;

  assign dbl = {req, req};

  // Scan the doubled request vector from ptr for N positions; the upper copy handles wrap.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < 2*N; k++) begin
      if (!found && (k >= int'(ptr)) && (k < int'(ptr) + N) && dbl[k]) begin
        gnt[(k >= N) ? (k - N) : k] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign gnt_idx = SEL_W'(onehot_to_idx(32'(gnt)));

endmodule

// File: rtl/mux_arb_nto1.sv
// rtl/mux_arb_nto1.sv - N-to-1 registered mux with select or round-robin arbitration
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_nto1_if.slave bus
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     sel_gnt;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             accept;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Select-mode grant; an out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      sel_gnt[i] = bus.in_valid[i] && (bus.sel == SEL_W'(i));
    end
  end

  assign grant     = (bus.mode_rr == MODE_RR) ? rr_gnt : sel_gnt;
  assign grant_idx = SEL_W'(onehot_to_idx(32'(grant)));
  assign load      = !bus.out_valid || bus.out_ready;
  assign accept    = rst_n && load && (|grant);
  assign bus.in_ready = (rst_n && load) ? grant : '0;

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) word = word | bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      rr_ptr        <= '0;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= word;
        bus.out_src   <= grant_idx;
        if (bus.mode_rr == MODE_RR) begin
          rr_ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
